// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the auto-sequenced conv core.
//  - array/tile geometry and derived lengths (LEN_NIJ, LEN_KIJ, O_W, LEN_ONIJ)
//  - memory address widths and phase lengths used by the sequencer
//  - sequencer state enum and corelet mode codes
//  - mac_lane(): one output-channel dot product (signed weights x unsigned acts)
package core_pkg;

  localparam int BW       = 4;
  localparam int PSUM_BW  = 16;
  localparam int ROW      = 8;
  localparam int COL      = 8;
  localparam int IN_W     = 6;
  localparam int K_W      = 3;
  localparam int XMEM_AW  = 11;

  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_KIJ  = K_W * K_W;
  localparam int O_W      = IN_W - K_W + 1;
  localparam int LEN_ONIJ = O_W * O_W;

  localparam int WORD_W     = BW * ROW;
  localparam int PSUM_W     = PSUM_BW * COL;
  localparam int PSUM_DEPTH = LEN_KIJ * LEN_NIJ;
  localparam int PSUM_AW    = $clog2(PSUM_DEPTH);
  localparam int OUT_AW     = $clog2(LEN_ONIJ);
  localparam int KIJ_W      = $clog2(LEN_KIJ);
  localparam int KW_W       = $clog2(K_W);
  localparam int OW_W       = $clog2(O_W);
  localparam int CNT_W      = 6;

  // Last counter value of each phase.
  // WLOAD: COL reads, 1 return cycle, COL l0_rd cycles, ROW+COL flush cycles.
  localparam int WLOAD_LAST = COL + 1 + COL + ROW + COL - 1;
  // EXEC / DRAIN: LEN_NIJ requests plus one cycle for the last response.
  localparam int EXEC_LAST  = LEN_NIJ;
  localparam int DRAIN_LAST = LEN_NIJ;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WLOAD = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ACC   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_EXEC = 2'b10
  } mode_t;

  // Dot product of one weight column with one activation word.
  // Weights are signed BW-bit, activations unsigned BW-bit; result wraps mod 2^PSUM_BW.
  function automatic logic [PSUM_BW-1:0] mac_lane(input logic [WORD_W-1:0] w_col,
                                                  input logic [WORD_W-1:0] act);
    logic signed [PSUM_BW-1:0] acc;
    logic signed [PSUM_BW-1:0] wv;
    logic signed [PSUM_BW-1:0] av;
    acc = '0;
    for (int r = 0; r < ROW; r++) begin
      wv  = PSUM_BW'($signed(w_col[r*BW +: BW]));
      av  = $signed(PSUM_BW'(act[r*BW +: BW]));
      acc = acc + wv * av;
    end
    return acc;
  endfunction

endpackage

// File: rtl/core_onij_accum.sv
// core_onij_accum: kij-accumulation engine.
//  On start, walks onij=0..LEN_ONIJ-1 (outer) and kij=0..LEN_KIJ-1 (inner),
//  issuing one psum-SRAM read per cycle at kij*LEN_NIJ+(oi+ki)*IN_W+(oj+kj).
//  Read data (1-cycle latency) is summed per lane (COL signed lanes, wrapping);
//  the accumulator restarts on each kij=0 term. The finished sum is written to
//  output SRAM address onij on the cycle after its last term arrives.
//  Optional feature macro CORE_RELU_EN: negative lanes clamp to 0 before the write.
// Ports:
//  clk, reset        clock, synchronous active-high reset
//  start             1-cycle pulse, begins a full accumulation pass
//  psum_rd_en/addr   psum SRAM read request
//  psum_rd_data      psum SRAM registered read data
//  out_wr_en/addr/data  output SRAM write
//  done              high in the cycle the final onij result is written
module core_onij_accum
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               psum_rd_en,
  output logic [PSUM_AW-1:0] psum_rd_addr,
  input  logic [PSUM_W-1:0]  psum_rd_data,
  output logic               out_wr_en,
  output logic [OUT_AW-1:0]  out_wr_addr,
  output logic [PSUM_W-1:0]  out_wr_data,
  output logic               done
);

  logic              active_reg;
  logic [KW_W-1:0]   ki_reg, kj_reg;
  logic [OW_W-1:0]   oi_reg, oj_reg;
  logic [KIJ_W-1:0]  kij_reg;
  logic [OUT_AW-1:0] onij_reg;

  logic              rd_valid_reg;
  logic              rd_first_reg;
  logic              rd_last_reg;
  logic [OUT_AW-1:0] rd_onij_reg;

  logic              out_wr_en_reg;
  logic [OUT_AW-1:0] out_wr_addr_reg;
  logic [PSUM_W-1:0] out_wr_data_reg;
  logic [PSUM_W-1:0] result_word;

  logic last_kij;
  logic last_onij;

  assign last_kij  = (kij_reg == KIJ_W'(LEN_KIJ - 1));
  assign last_onij = (onij_reg == OUT_AW'(LEN_ONIJ - 1));

  assign psum_rd_en   = active_reg;
  assign psum_rd_addr = PSUM_AW'(int'(kij_reg) * LEN_NIJ
                                 + (int'(oi_reg) + int'(ki_reg)) * IN_W
                                 + int'(oj_reg) + int'(kj_reg));

  // Address generator: kj fastest, then ki, then oj, then oi.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg <= 1'b0;
      ki_reg     <= '0;
      kj_reg     <= '0;
      oi_reg     <= '0;
      oj_reg     <= '0;
      kij_reg    <= '0;
      onij_reg   <= '0;
    end else if (start) begin
      active_reg <= 1'b1;
      ki_reg     <= '0;
      kj_reg     <= '0;
      oi_reg     <= '0;
      oj_reg     <= '0;
      kij_reg    <= '0;
      onij_reg   <= '0;
    end else if (active_reg) begin
      if (kj_reg == KW_W'(K_W - 1)) begin
        kj_reg <= '0;
        ki_reg <= (ki_reg == KW_W'(K_W - 1)) ? '0 : ki_reg + 1'b1;
      end else begin
        kj_reg <= kj_reg + 1'b1;
      end
      if (last_kij) begin
        kij_reg  <= '0;
        onij_reg <= onij_reg + 1'b1;
        if (oj_reg == OW_W'(O_W - 1)) begin
          oj_reg <= '0;
          oi_reg <= oi_reg + 1'b1;
        end else begin
          oj_reg <= oj_reg + 1'b1;
        end
        if (last_onij) begin
          active_reg <= 1'b0;
        end
      end else begin
        kij_reg <= kij_reg + 1'b1;
      end
    end
  end

  // Tag each read so the sum knows when to restart and when to commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      rd_first_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      rd_onij_reg  <= '0;
    end else begin
      rd_valid_reg <= active_reg;
      rd_first_reg <= (kij_reg == '0);
      rd_last_reg  <= last_kij;
      rd_onij_reg  <= onij_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < COL; gi++) begin : g_lane
      logic [PSUM_BW-1:0] acc_reg;
      logic [PSUM_BW-1:0] sum_lane;

      assign sum_lane = (rd_first_reg ? '0 : acc_reg) + psum_rd_data[gi*PSUM_BW +: PSUM_BW];

      always_ff @(posedge clk) begin
        if (reset) begin
          acc_reg <= '0;
        end else if (rd_valid_reg) begin
          acc_reg <= sum_lane;
        end
      end

`ifdef CORE_RELU_EN
      assign result_word[gi*PSUM_BW +: PSUM_BW] = sum_lane[PSUM_BW-1] ? '0 : sum_lane;
`else
      assign result_word[gi*PSUM_BW +: PSUM_BW] = sum_lane;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr_en_reg   <= 1'b0;
      out_wr_addr_reg <= '0;
      out_wr_data_reg <= '0;
    end else begin
      out_wr_en_reg   <= rd_valid_reg && rd_last_reg;
      out_wr_addr_reg <= rd_onij_reg;
      out_wr_data_reg <= result_word;
    end
  end

  assign out_wr_en   = out_wr_en_reg;
  assign out_wr_addr = out_wr_addr_reg;
  assign out_wr_data = out_wr_data_reg;
  assign done        = out_wr_en_reg && (out_wr_addr_reg == OUT_AW'(LEN_ONIJ - 1));

endmodule

// File: rtl/core_auto_seq.sv
// core_auto_seq: self-sequenced conv core.
//  Host preloads xmem (activations at act_base+nij, weights at wgt_base+kij*COL+c,
//  word lane r = input channel r), pulses start, waits for done, then reads the
//  LEN_ONIJ results from the output SRAM. Per kij the sequencer loads a weight
//  tile (WLOAD), streams all activations through the array (EXEC), drains the
//  ofifo into psum SRAM (DRAIN); after the last kij the accumulation engine
//  builds the outputs (ACC).
//  Optional feature macro CORE_RELU_EN (handled in core_onij_accum).
// Ports:
//  clk, reset            clock, synchronous active-high reset
//  start                 begin run (only honoured in IDLE)
//  dbi_en                data-bus-inversion on the xmem->L0 link
//  act_base, wgt_base    xmem base addresses
//  xmem_wr/addr, D_xmem  host xmem write port (dropped while busy)
//  out_rd_en/addr        host output SRAM read (refused while busy)
//  out_rd_data/valid     host read data, 1 cycle after out_rd_en
//  busy, done, err       status: run active / end-of-run pulse / illegal access pulse
module core_auto_seq
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dbi_en,
  input  logic [XMEM_AW-1:0] act_base,
  input  logic [XMEM_AW-1:0] wgt_base,
  input  logic               xmem_wr,
  input  logic [XMEM_AW-1:0] xmem_addr,
  input  logic [WORD_W-1:0]  D_xmem,
  input  logic               out_rd_en,
  input  logic [OUT_AW-1:0]  out_rd_addr,
  output logic [PSUM_W-1:0]  out_rd_data,
  output logic               out_rd_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t            state_reg, state_next;
  mode_t             mode;
  logic [CNT_W-1:0]  cnt_reg;
  logic [KIJ_W-1:0]  kij_reg;
  logic              acc_start;
  logic              acc_done;

  // xmem
  logic [WORD_W-1:0]  xmem_mem [0:(1<<XMEM_AW)-1];
  logic               x_rd_en;
  logic [XMEM_AW-1:0] x_rd_addr;
  logic [CNT_W-1:0]   x_rd_tag;
  logic [WORD_W-1:0]  x_rd_raw_reg;
  logic               x_rd_valid_reg;
  logic [CNT_W-1:0]   x_rd_tag_reg;
  logic               x_inv;
  logic [WORD_W-1:0]  l0_bus;
  logic [WORD_W-1:0]  l0_word;

  // array output / ofifo
  logic [PSUM_W-1:0]  mac_word;
  logic [PSUM_W-1:0]  ofifo_mem [0:LEN_NIJ-1];
  logic [CNT_W-1:0]   ofifo_count_reg;
  logic               ofifo_valid;
  logic               ofifo_rd;
  logic [PSUM_W-1:0]  ofifo_rd_data_reg;
  logic               ofifo_rd_valid_reg;
  logic [CNT_W-1:0]   drain_idx_reg;

  // psum SRAM
  logic [PSUM_W-1:0]  psum_mem [0:PSUM_DEPTH-1];
  logic [PSUM_AW-1:0] psum_wr_addr;
  logic               psum_rd_en;
  logic [PSUM_AW-1:0] psum_rd_addr;
  logic [PSUM_W-1:0]  psum_rd_data_reg;

  // output SRAM
  logic [PSUM_W-1:0]  out_mem [0:LEN_ONIJ-1];
  logic               out_wr_en;
  logic [OUT_AW-1:0]  out_wr_addr;
  logic [PSUM_W-1:0]  out_wr_data;
  logic [PSUM_W-1:0]  out_rd_data_reg;
  logic               out_rd_valid_reg;
  logic               err_reg;
  logic               host_rd_ok;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_WLOAD;
      ST_WLOAD: if (cnt_reg == CNT_W'(WLOAD_LAST)) state_next = ST_EXEC;
      ST_EXEC:  if (cnt_reg == CNT_W'(EXEC_LAST)) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (cnt_reg == CNT_W'(DRAIN_LAST)) begin
          state_next = (kij_reg == KIJ_W'(LEN_KIJ - 1)) ? ST_ACC : ST_WLOAD;
        end
      end
      ST_ACC:   if (acc_done) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (state_reg != ST_IDLE);
    done      = (state_reg == ST_DONE);
    mode      = MODE_IDLE;
    acc_start = (state_reg == ST_DRAIN) && (state_next == ST_ACC);
    case (state_reg)
      ST_WLOAD: mode = MODE_LOAD;
      ST_EXEC:  mode = MODE_EXEC;
      default:  mode = MODE_IDLE;
    endcase
  end

  // Phase counter restarts on every state change; kij advances between tiles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      kij_reg <= '0;
    end else begin
      if (state_next != state_reg) begin
        cnt_reg <= '0;
      end else if (mode != MODE_IDLE || state_reg == ST_DRAIN) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == ST_IDLE) begin
        kij_reg <= '0;
      end else if (state_reg == ST_DRAIN && state_next == ST_WLOAD) begin
        kij_reg <= kij_reg + 1'b1;
      end
    end
  end

  // ---------------- xmem ----------------
  always_comb begin
    x_rd_en   = 1'b0;
    x_rd_addr = '0;
    x_rd_tag  = '0;
    if (state_reg == ST_WLOAD && cnt_reg < CNT_W'(COL)) begin
      x_rd_en   = 1'b1;
      x_rd_addr = wgt_base + XMEM_AW'(int'(kij_reg) * COL) + XMEM_AW'(cnt_reg);
      x_rd_tag  = cnt_reg;
    end else if (state_reg == ST_EXEC && cnt_reg < CNT_W'(LEN_NIJ)) begin
      x_rd_en   = 1'b1;
      x_rd_addr = act_base + XMEM_AW'(cnt_reg);
      x_rd_tag  = cnt_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (xmem_wr && state_reg == ST_IDLE) begin
      xmem_mem[xmem_addr] <= D_xmem;
    end
    if (x_rd_en) begin
      x_rd_raw_reg <= xmem_mem[x_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_rd_valid_reg <= 1'b0;
      x_rd_tag_reg   <= '0;
    end else begin
      x_rd_valid_reg <= x_rd_en;
      x_rd_tag_reg   <= x_rd_tag;
    end
  end

  // DBI: words with more than half their bits set cross the link inverted
  // and are restored on the corelet side, so the array sees the true word.
  assign x_inv   = dbi_en && ($countones(x_rd_raw_reg) > WORD_W / 2);
  assign l0_bus  = x_inv ? ~x_rd_raw_reg : x_rd_raw_reg;
  assign l0_word = x_inv ? ~l0_bus : l0_bus;

  // ---------------- corelet: L0 staging + weight-stationary columns ----------------
  // Column gi is staged into L0 when its weight word returns, then moved into
  // the array during its l0_rd slot; the trailing ROW+COL cycles flush the load.
  genvar gi;
  generate
    for (gi = 0; gi < COL; gi++) begin : g_col
      logic [WORD_W-1:0] l0_w_reg;
      logic [WORD_W-1:0] w_col_reg;

      always_ff @(posedge clk) begin
        if (mode == MODE_LOAD && x_rd_valid_reg && x_rd_tag_reg == CNT_W'(gi)) begin
          l0_w_reg <= l0_word;
        end
        if (mode == MODE_LOAD && cnt_reg == CNT_W'(COL + 1 + gi)) begin
          w_col_reg <= l0_w_reg;
        end
      end

      assign mac_word[gi*PSUM_BW +: PSUM_BW] = mac_lane(w_col_reg, l0_word);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (mode == MODE_EXEC && x_rd_valid_reg) begin
      ofifo_mem[x_rd_tag_reg] <= mac_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ofifo_count_reg <= '0;
    end else if (state_reg == ST_WLOAD) begin
      ofifo_count_reg <= '0;
    end else if (mode == MODE_EXEC && x_rd_valid_reg) begin
      ofifo_count_reg <= ofifo_count_reg + 1'b1;
    end
  end

  // ---------------- DRAIN: ofifo -> psum SRAM ----------------
  assign ofifo_valid = (cnt_reg < ofifo_count_reg);
  assign ofifo_rd    = (state_reg == ST_DRAIN) && (cnt_reg < CNT_W'(LEN_NIJ)) && ofifo_valid;

  always_ff @(posedge clk) begin
    if (ofifo_rd) begin
      ofifo_rd_data_reg <= ofifo_mem[cnt_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ofifo_rd_valid_reg <= 1'b0;
      drain_idx_reg      <= '0;
    end else begin
      ofifo_rd_valid_reg <= ofifo_rd;
      drain_idx_reg      <= cnt_reg;
    end
  end

  assign psum_wr_addr = PSUM_AW'(int'(kij_reg) * LEN_NIJ + int'(drain_idx_reg));

  always_ff @(posedge clk) begin
    if (ofifo_rd_valid_reg) begin
      psum_mem[psum_wr_addr] <= ofifo_rd_data_reg;
    end
    if (psum_rd_en) begin
      psum_rd_data_reg <= psum_mem[psum_rd_addr];
    end
  end

  // ---------------- ACC ----------------
  core_onij_accum u_accum (
    .clk          (clk),
    .reset        (reset),
    .start        (acc_start),
    .psum_rd_en   (psum_rd_en),
    .psum_rd_addr (psum_rd_addr),
    .psum_rd_data (psum_rd_data_reg),
    .out_wr_en    (out_wr_en),
    .out_wr_addr  (out_wr_addr),
    .out_wr_data  (out_wr_data),
    .done         (acc_done)
  );

  // ---------------- output SRAM + host read ----------------
  always_ff @(posedge clk) begin
    if (out_wr_en) begin
      out_mem[out_wr_addr] <= out_wr_data;
    end
  end

  assign host_rd_ok = out_rd_en && !busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_rd_valid_reg <= 1'b0;
      out_rd_data_reg  <= '0;
      err_reg          <= 1'b0;
    end else begin
      out_rd_valid_reg <= host_rd_ok;
      if (host_rd_ok) begin
        out_rd_data_reg <= out_mem[out_rd_addr];
      end
      err_reg <= busy && (xmem_wr || out_rd_en);
    end
  end

  assign out_rd_data  = out_rd_data_reg;
  assign out_rd_valid = out_rd_valid_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_core_auto_seq.sv
// Directed testbench for core_auto_seq: reset, uniform runs, sparse-kernel run,
// illegal host access mid-run, and reset in the middle of a run.
module tb_core_auto_seq;
  import core_pkg::*;

  localparam int ACT_BASE = 0;
  localparam int WGT_BASE = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               dbi_en;
  logic [XMEM_AW-1:0] act_base;
  logic [XMEM_AW-1:0] wgt_base;
  logic               xmem_wr;
  logic [XMEM_AW-1:0] xmem_addr;
  logic [WORD_W-1:0]  D_xmem;
  logic               out_rd_en;
  logic [OUT_AW-1:0]  out_rd_addr;
  logic [PSUM_W-1:0]  out_rd_data;
  logic               out_rd_valid;
  logic               busy;
  logic               done;
  logic               err;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  core_auto_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dbi_en       (dbi_en),
    .act_base     (act_base),
    .wgt_base     (wgt_base),
    .xmem_wr      (xmem_wr),
    .xmem_addr    (xmem_addr),
    .D_xmem       (D_xmem),
    .out_rd_en    (out_rd_en),
    .out_rd_addr  (out_rd_addr),
    .out_rd_data  (out_rd_data),
    .out_rd_valid (out_rd_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  task automatic check(input string tag, input logic [PSUM_W-1:0] got, input logic [PSUM_W-1:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_x(input int a, input logic [WORD_W-1:0] d);
    xmem_wr   = 1'b1;
    xmem_addr = XMEM_AW'(a);
    D_xmem    = d;
    tick();
    xmem_wr   = 1'b0;
  endtask

  task automatic load_uniform(input logic [WORD_W-1:0] w, input logic [WORD_W-1:0] a);
    for (int n = 0; n < LEN_NIJ; n++) wr_x(ACT_BASE + n, a);
    for (int k = 0; k < LEN_KIJ * COL; k++) wr_x(WGT_BASE + k, w);
  endtask

  // Only kij=4, column 0, row 0 weight is 1; act lane0 = nij%16.
  task automatic load_sparse();
    for (int n = 0; n < LEN_NIJ; n++) wr_x(ACT_BASE + n, WORD_W'(n % 16));
    for (int k = 0; k < LEN_KIJ * COL; k++) wr_x(WGT_BASE + k, (k == 4 * COL) ? WORD_W'(1) : WORD_W'(0));
  endtask

  task automatic wait_done(input string tag);
    int  dones;
    bit  seen;
    dones = 0;
    seen  = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      tick();
      if (done) begin
        dones++;
        seen = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
    end
    check({tag, "_done_cnt"}, PSUM_W'(dones), PSUM_W'(1));
    check({tag, "_busy_end"}, PSUM_W'(busy), PSUM_W'(0));
  endtask

  task automatic run(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, PSUM_W'(busy), PSUM_W'(1));
    wait_done(tag);
  endtask

  // kind 0: all lanes 72; kind 1: all lanes -72 (or 0 with ReLU); kind 2: sparse kernel
  task automatic check_outputs(input string tag, input int kind);
    logic [PSUM_W-1:0] exp;
    int oi, oj;
    for (int o = 0; o < LEN_ONIJ; o++) begin
      out_rd_en   = 1'b1;
      out_rd_addr = OUT_AW'(o);
      tick();
      out_rd_en   = 1'b0;
      oi = o / O_W;
      oj = o % O_W;
      exp = '0;
      if (kind == 0) begin
        exp = {COL{16'h0048}};
      end else if (kind == 1) begin
`ifdef CORE_RELU_EN
        exp = {COL{16'h0000}};
`else
        exp = {COL{16'hFFB8}};
`endif
      end else begin
        exp[PSUM_BW-1:0] = PSUM_BW'(((oi + 1) * IN_W + oj + 1) % 16);
      end
      check($sformatf("%s_valid%0d", tag, o), PSUM_W'(out_rd_valid), PSUM_W'(1));
      check($sformatf("%s_out%0d", tag, o), out_rd_data, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    dbi_en      = 1'b0;
    act_base    = XMEM_AW'(ACT_BASE);
    wgt_base    = XMEM_AW'(WGT_BASE);
    xmem_wr     = 1'b0;
    xmem_addr   = '0;
    D_xmem      = '0;
    out_rd_en   = 1'b0;
    out_rd_addr = '0;

    // 1: reset
    repeat (3) tick();
    reset = 1'b0;
    check("t1_busy", PSUM_W'(busy), PSUM_W'(0));
    check("t1_done", PSUM_W'(done), PSUM_W'(0));
    check("t1_err", PSUM_W'(err), PSUM_W'(0));
    check("t1_rd_valid", PSUM_W'(out_rd_valid), PSUM_W'(0));
    check("t1_rd_data", out_rd_data, PSUM_W'(0));
    // start together with reset: reset wins
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("t1_start_reset", PSUM_W'(busy), PSUM_W'(0));

    // 2: all ones
    load_uniform({ROW{4'h1}}, {ROW{4'h1}});
    run("t2");
    check_outputs("t2", 0);

    // 3: weights -1, with DBI active on the link
    dbi_en = 1'b1;
    load_uniform({ROW{4'hF}}, {ROW{4'h1}});
    run("t3");
    check_outputs("t3", 1);
    dbi_en = 1'b0;

    // 4: single centre tap
    load_sparse();
    run("t4");
    check_outputs("t4", 2);

    // 5: illegal host traffic mid-run
    load_uniform({ROW{4'h1}}, {ROW{4'h1}});
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    xmem_wr   = 1'b1;
    xmem_addr = XMEM_AW'(ACT_BASE);
    D_xmem    = 32'hDEADBEEF;
    tick();
    xmem_wr   = 1'b0;
    check("t5_err_xmem", PSUM_W'(err), PSUM_W'(1));
    tick();
    check("t5_err_clear", PSUM_W'(err), PSUM_W'(0));
    out_rd_en   = 1'b1;
    out_rd_addr = '0;
    tick();
    out_rd_en   = 1'b0;
    check("t5_err_rd", PSUM_W'(err), PSUM_W'(1));
    check("t5_rd_valid", PSUM_W'(out_rd_valid), PSUM_W'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_start_noerr", PSUM_W'(err), PSUM_W'(0));
    check("t5_still_busy", PSUM_W'(busy), PSUM_W'(1));
    wait_done("t5");
    check_outputs("t5", 0);

    // 6: reset during the kij=4 drain, then rerun
    load_sparse();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (510) tick();
    check("t6_busy_mid", PSUM_W'(busy), PSUM_W'(1));
    reset = 1'b1;
    tick();
    check("t6_busy_reset", PSUM_W'(busy), PSUM_W'(0));
    check("t6_done_reset", PSUM_W'(done), PSUM_W'(0));
    reset = 1'b0;
    load_uniform({ROW{4'h1}}, {ROW{4'h1}});
    run("t6");
    check_outputs("t6", 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
